// File: rtl/nfa_engine_param.sv
// Parametrised one-hot NFA match engine: one flop per state, graph/classes/start/accept
// supplied as parameters; reports match pulse, sticky flag, saturating count and offsets.
module nfa_engine_param #(
    parameter int unsigned NUM_STATES  = 16,
    parameter int unsigned NUM_CLASSES = 32,
    parameter int unsigned CLW         = 5,
    parameter logic [NUM_STATES*CLW-1:0]        STATE_CLASS = '0,
    parameter logic [NUM_STATES*NUM_STATES-1:0] PRED_MASK   = '0,
    parameter logic [NUM_STATES-1:0]            START_MASK  = '0,
    parameter logic [NUM_STATES-1:0]            ACCEPT_MASK = '0,
    parameter int unsigned ANCHORED    = 0,
    parameter int unsigned POS_W       = 16,
    parameter int unsigned CNT_W       = 8
) (
    input  logic                   clk,
    input  logic                   sod,
    input  logic                   en,
    input  logic [NUM_CLASSES-1:0] cls_in,
    output logic [NUM_STATES-1:0]  state_vec,
    output logic                   match_pulse,
    output logic                   match_sticky,
    output logic [CNT_W-1:0]       match_count,
    output logic [POS_W-1:0]       first_pos,
    output logic [POS_W-1:0]       last_pos,
    output logic                   pos_ovf
);

    localparam int unsigned NS = NUM_STATES;

    logic [NS-1:0]    r_state;
    logic             r_pulse;
    logic             r_sticky;
    logic [CNT_W-1:0] r_count;
    logic [POS_W-1:0] r_first;
    logic [POS_W-1:0] r_last;
    logic [POS_W-1:0] r_byte_pos;
    logic             r_pos_ovf;

    logic [NS-1:0]    w_cls_hit;
    logic [NS-1:0]    w_pred;
    logic [NS-1:0]    w_next;
    logic             w_start_act;
    logic             w_hit;
    logic [POS_W-1:0] w_pos_next;

    assign w_start_act = (ANCHORED != 0) ? (r_byte_pos == '0) : 1'b1;

    // Class indices that match no decoded class leave the state's class hit at 0.
    always_comb begin
        w_cls_hit = '0;
        w_pred    = '0;
        w_next    = '0;
        for (int i = 0; i < NS; i++) begin
            for (int c = 0; c < NUM_CLASSES; c++) begin
                if (STATE_CLASS[i*CLW +: CLW] == CLW'(c)) begin
                    w_cls_hit[i] = cls_in[c];
                end
            end
            w_pred[i] = START_MASK[i] & w_start_act;
            for (int j = 0; j < NS; j++) begin
                w_pred[i] = w_pred[i] | (r_state[j] & PRED_MASK[i*NS + j]);
            end
            w_next[i] = w_cls_hit[i] & w_pred[i];
        end
    end

    assign w_hit      = |(w_next & ACCEPT_MASK);
    assign w_pos_next = (r_byte_pos == '1) ? r_byte_pos : r_byte_pos + POS_W'(1);

    always_ff @(posedge clk) begin
        if (sod) begin
            r_state    <= '0;
            r_pulse    <= 1'b0;
            r_sticky   <= 1'b0;
            r_count    <= '0;
            r_first    <= '0;
            r_last     <= '0;
            r_byte_pos <= '0;
            r_pos_ovf  <= 1'b0;
        end else begin
            r_pulse <= en & w_hit;
            if (en) begin
                r_state    <= w_next;
                r_byte_pos <= w_pos_next;
                if (w_pos_next == '1) begin
                    r_pos_ovf <= 1'b1;
                end
                if (w_hit) begin
                    r_sticky <= 1'b1;
                    r_last   <= r_byte_pos;
                    if (r_count != '1) begin
                        r_count <= r_count + CNT_W'(1);
                    end
                    if (!r_sticky) begin
                        r_first <= r_byte_pos;
                    end
                end
            end
        end
    end

    assign state_vec    = r_state;
    assign match_pulse  = r_pulse;
    assign match_sticky = r_sticky;
    assign match_count  = r_count;
    assign first_pos    = r_first;
    assign last_pos     = r_last;
    assign pos_ovf      = r_pos_ovf;

endmodule
